// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a dual-port FIFO RAM, read clock domain.
// Owns the read pointer, drives the RAM read address/strobe, synchronises the
// write-domain Gray pointer and produces registered empty/almost-empty/level
// status plus a one-cycle underflow pulse.
module fifo_rd_ctrl #(
    parameter int ASIZE    = 4,
    parameter int AE_LEVEL = 2
) (
    input  logic             rd_clk,
    input  logic             rd_rst_n,
    input  logic             rd_en,
    input  logic [ASIZE:0]   wr_ptr_gray,
    output logic             rd_inc,
    output logic [ASIZE-1:0] rd_addr,
    output logic [ASIZE:0]   rd_ptr_gray,
    output logic             rd_empty,
    output logic             rd_almost_empty,
    output logic [ASIZE:0]   rd_level,
    output logic             rd_underflow
);

    localparam logic [ASIZE:0] AE_THRESH = (ASIZE+1)'(AE_LEVEL);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [ASIZE:0] sync1_q, sync1_d;
    logic [ASIZE:0] sync2_q, sync2_d;
    logic [ASIZE:0] rd_bin_q, rd_bin_d;
    logic [ASIZE:0] rd_ptr_gray_q, rd_ptr_gray_d;
    logic           rd_empty_q, rd_empty_d;
    logic           rd_almost_empty_q, rd_almost_empty_d;
    logic [ASIZE:0] rd_level_q, rd_level_d;
    logic           rd_underflow_q, rd_underflow_d;

    // The read strobe is gated by the registered empty flag, so a read while
    // empty never moves the pointer.
    assign rd_inc = rd_en & ~rd_empty_q;

    // Next-state: pointer advance, two-flop synchroniser shift and status flags.
    // Flags compare against the post-read pointer so the read that drains the
    // last visible word raises empty on that same edge.
    always_comb begin
        sync1_d           = wr_ptr_gray;
        sync2_d           = sync1_q;
        rd_bin_d          = rd_bin_q + {{ASIZE{1'b0}}, rd_inc};
        rd_ptr_gray_d     = bin2gray(rd_bin_d);
        rd_empty_d        = (rd_ptr_gray_d == sync2_q);
        rd_level_d        = gray2bin(sync2_q) - rd_bin_d;
        rd_almost_empty_d = (rd_level_d <= AE_THRESH);
        rd_underflow_d    = rd_en & rd_empty_q;
    end

    // State registers; reset is asynchronous so outputs clear without a clock.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            sync1_q           <= '0;
            sync2_q           <= '0;
            rd_bin_q          <= '0;
            rd_ptr_gray_q     <= '0;
            rd_empty_q        <= 1'b1;
            rd_almost_empty_q <= 1'b1;
            rd_level_q        <= '0;
            rd_underflow_q    <= 1'b0;
        end else begin
            sync1_q           <= sync1_d;
            sync2_q           <= sync2_d;
            rd_bin_q          <= rd_bin_d;
            rd_ptr_gray_q     <= rd_ptr_gray_d;
            rd_empty_q        <= rd_empty_d;
            rd_almost_empty_q <= rd_almost_empty_d;
            rd_level_q        <= rd_level_d;
            rd_underflow_q    <= rd_underflow_d;
        end
    end

    assign rd_addr         = rd_bin_q[ASIZE-1:0];
    assign rd_ptr_gray     = rd_ptr_gray_q;
    assign rd_empty        = rd_empty_q;
    assign rd_almost_empty = rd_almost_empty_q;
    assign rd_level        = rd_level_q;
    assign rd_underflow    = rd_underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl. A counting model tracks how many words
// have been written and read as plain integers; the write count becomes visible
// to the reader two edges late.
module tb_fifo_rd_ctrl;

    localparam int ASIZE = 4;
    localparam int DEPTH = 16;
    localparam int AE    = 2;

    logic             rd_clk = 1'b0;
    logic             rd_rst_n = 1'b0;
    logic             rd_en = 1'b0;
    logic [ASIZE:0]   wr_ptr_gray = '0;
    logic             rd_inc;
    logic [ASIZE-1:0] rd_addr;
    logic [ASIZE:0]   rd_ptr_gray;
    logic             rd_empty;
    logic             rd_almost_empty;
    logic [ASIZE:0]   rd_level;
    logic             rd_underflow;

    fifo_rd_ctrl #(.ASIZE(ASIZE), .AE_LEVEL(AE)) dut (
        .rd_clk          (rd_clk),
        .rd_rst_n        (rd_rst_n),
        .rd_en           (rd_en),
        .wr_ptr_gray     (wr_ptr_gray),
        .rd_inc          (rd_inc),
        .rd_addr         (rd_addr),
        .rd_ptr_gray     (rd_ptr_gray),
        .rd_empty        (rd_empty),
        .rd_almost_empty (rd_almost_empty),
        .rd_level        (rd_level),
        .rd_underflow    (rd_underflow)
    );

    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: true (unwrapped) counts.
    int  wr_cnt;     // words written by the producer
    int  m_rd;       // words consumed
    int  m_s1, m_s2; // write count as seen through each synchroniser stage
    int  m_level;
    bit  m_empty;
    bit  m_under;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [ASIZE:0] to_gray(input int n);
        logic [ASIZE:0] b;
        b = (ASIZE+1)'(n % (2*DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_addr"},  32'(rd_addr),         32'(m_rd % DEPTH));
        check({tag, "_gray"},  32'(rd_ptr_gray),     32'(to_gray(m_rd)));
        check({tag, "_empty"}, 32'(rd_empty),        32'(m_empty));
        check({tag, "_ae"},    32'(rd_almost_empty), 32'(m_level <= AE));
        check({tag, "_level"}, 32'(rd_level),        32'(m_level));
        check({tag, "_uflow"}, 32'(rd_underflow),    32'(m_under));
    endtask

    task automatic model_reset();
        wr_cnt = 0; m_rd = 0; m_s1 = 0; m_s2 = 0;
        m_level = 0; m_empty = 1'b1; m_under = 1'b0;
        wr_ptr_gray = '0;
    endtask

    // Reset values must be visible with no clock edge.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, 32'(rd_empty),        32'd1);
        check({tag, "_ae"},    32'(rd_almost_empty), 32'd1);
        check({tag, "_level"}, 32'(rd_level),        32'd0);
        check({tag, "_gray"},  32'(rd_ptr_gray),     32'd0);
        check({tag, "_addr"},  32'(rd_addr),         32'd0);
        check({tag, "_inc"},   32'(rd_inc),          32'd0);
        check({tag, "_uflow"}, 32'(rd_underflow),    32'd0);
    endtask

    // Enter with the clock just past a rising edge; leave the same way.
    task automatic do_reset();
        rd_rst_n = 1'b0;
        rd_en    = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("rst");
        @(posedge rd_clk);
        @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
    endtask

    // One read-clock cycle: optional producer write (never beyond full),
    // optional read request, check the strobe before the edge and every
    // registered output after it.
    task automatic step(input bit en, input bit wr);
        bit exp_inc;
        int vis;
        if (wr && (wr_cnt - m_rd) < DEPTH) wr_cnt++;
        wr_ptr_gray = to_gray(wr_cnt);
        rd_en = en;
        @(negedge rd_clk);
        exp_inc = en && !m_empty;
        check("rd_inc", 32'(rd_inc), 32'(exp_inc));
        @(posedge rd_clk);
        m_under = en && m_empty;
        if (exp_inc) m_rd++;
        vis     = m_s2;
        m_s2    = m_s1;
        m_s1    = wr_cnt;
        m_level = vis - m_rd;
        m_empty = (m_level == 0);
        #1;
        check_regs("step");
    endtask

    initial begin
        model_reset();
        @(posedge rd_clk);
        #1;
        do_reset();

        // One word: visible on the 3rd edge, then consumed.
        step(1'b0, 1'b1);
        check("t2_still_empty1", 32'(rd_empty), 32'd1);
        step(1'b0, 1'b0);
        check("t2_still_empty2", 32'(rd_empty), 32'd1);
        step(1'b0, 1'b0);
        check("t2_empty", 32'(rd_empty), 32'd0);
        check("t2_level", 32'(rd_level), 32'd1);
        rd_en = 1'b1;
        #1;
        check("t2_inc",  32'(rd_inc),  32'd1);
        check("t2_addr", 32'(rd_addr), 32'd0);
        step(1'b1, 1'b0);
        check("t2_addr_after",  32'(rd_addr),     32'd1);
        check("t2_gray_after",  32'(rd_ptr_gray), 32'd1);
        check("t2_empty_after", 32'(rd_empty),    32'd1);

        // Underflow: read while empty holds pointer, pulses once.
        step(1'b1, 1'b0);
        check("t4_uflow",   32'(rd_underflow), 32'd1);
        check("t4_addr",    32'(rd_addr),      32'd1);
        step(1'b0, 1'b0);
        check("t4_uflow_clr", 32'(rd_underflow), 32'd0);

        // Full: 16 words from reset, then 16 reads.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("t3_wrgray", 32'(wr_ptr_gray),     32'h18);
        check("t3_level",  32'(rd_level),        32'd16);
        check("t3_ae",     32'(rd_almost_empty), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            check("t3_addr_seq", 32'(rd_addr), 32'(i));
            step(1'b1, 1'b0);
        end
        check("t3_addr_end",  32'(rd_addr),     32'd0);
        check("t3_gray_end",  32'(rd_ptr_gray), 32'h18);
        check("t3_empty_end", 32'(rd_empty),    32'd1);

        // Wrap: prefill 5 words, then stream 40 reads with one write per read.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1);
            check("t5_no_empty", 32'(rd_empty), 32'd0);
            if (i >= 1) begin
                check("t5_level3", 32'(rd_level),        32'd3);
                check("t5_ae0",    32'(rd_almost_empty), 32'd0);
            end
        end
        for (int i = 0; i < 12 && !m_empty; i++) begin
            step(1'b1, 1'b0);
            if (m_level == 2) check("t5_ae_at2", 32'(rd_almost_empty), 32'd1);
        end

        // Async reset mid-stream with level 5.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("t6_level5", 32'(rd_level), 32'd5);
        rd_en = 1'b1;
        #2;
        rd_rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("t6");
        @(posedge rd_clk);
        #1;
        check_reset_outputs("t6_hold");
        rd_rst_n = 1'b1;
        rd_en = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 55));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
